// File: rtl/regfile_dump_ctrl.sv
// regfile_dump_ctrl
//
// Read-side initiator for the 2R/1W register file. A start pulse walks
// x0..x(NREG-1) two registers at a time through the rs1/rs2 read ports and
// streams each value on a valid/ready interface, tagged with its index.
// Only read addresses are driven; the register file is never written.
//
// Ports:
//   i_clk          rising-edge clock
//   i_rst          synchronous, active-high reset
//   i_start        one-cycle dump request, honoured only in IDLE
//   o_busy         high from the cycle after an accepted start through DONE
//   o_done         one-cycle pulse after the last beat is accepted
//   o_rs1/o_rs2    read addresses for the even/odd register of the current pair
//   i_rd1/i_rd2    read data, combinational from o_rs1/o_rs2
//   o_out_valid    stream beat valid (never depends on i_out_ready)
//   i_out_ready    stream sink ready
//   o_out_data     register value
//   o_out_idx      register index of o_out_data
//   o_out_last     marks the beat for index NREG-1
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for i_start; read addresses parked at 0
// READ   | rs1=2k, rs2=2k+1 presented; rd1/rd2 captured at end of cycle
// SEND_A | beat for index 2k offered, held until accepted
// SEND_B | beat for index 2k+1 offered; last pair goes to DONE, else READ
// DONE   | one-cycle done pulse, then back to IDLE
//
// NREG must be even and >= 4 here so the pair counter has at least one bit;
// ADDR_W must equal clog2(NREG).

module regfile_dump_ctrl #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int ADDR_W = 5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_rs1,
    output logic [ADDR_W-1:0] o_rs2,
    input  logic [XLEN-1:0]   i_rd1,
    input  logic [XLEN-1:0]   i_rd2,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [XLEN-1:0]   o_out_data,
    output logic [ADDR_W-1:0] o_out_idx,
    output logic              o_out_last
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_SEND_A,
        S_SEND_B,
        S_DONE
    } state_t;

    // Pair counter is one bit narrower than a register index; the last-pair
    // compare stops it before it could wrap.
    localparam logic [ADDR_W-2:0] K_LAST = (ADDR_W-1)'(NREG/2 - 1);

    state_t              r_state;
    logic [ADDR_W-2:0]   r_k;
    logic [XLEN-1:0]     r_hold_a;
    logic [XLEN-1:0]     r_hold_b;
    logic                r_busy;
    logic                r_done;
    logic [ADDR_W-1:0]   r_rs1;
    logic [ADDR_W-1:0]   r_rs2;
    logic                r_out_valid;
    logic [XLEN-1:0]     r_out_data;
    logic [ADDR_W-1:0]   r_out_idx;
    logic                r_out_last;

    logic [ADDR_W-2:0]   w_k_next;

    assign w_k_next = r_k + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_k         <= '0;
            r_hold_a    <= '0;
            r_hold_b    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state <= S_READ;
                        r_k     <= '0;
                        r_busy  <= 1'b1;
                        r_rs1   <= '0;
                        r_rs2   <= ADDR_W'(1);
                    end
                end

                S_READ: begin
                    // Values are sampled once per pair here; later regfile
                    // writes do not disturb beats already captured.
                    r_hold_a    <= i_rd1;
                    r_hold_b    <= i_rd2;
                    r_out_valid <= 1'b1;
                    r_out_data  <= i_rd1;
                    r_out_idx   <= r_rs1;
                    r_out_last  <= 1'b0;
                    r_state     <= S_SEND_A;
                end

                S_SEND_A: begin
                    if (i_out_ready) begin
                        r_out_data <= r_hold_b;
                        r_out_idx  <= r_rs2;
                        r_out_last <= (r_k == K_LAST);
                        r_state    <= S_SEND_B;
                    end
                end

                S_SEND_B: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        if (r_out_last) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_k     <= w_k_next;
                            r_rs1   <= {w_k_next, 1'b0};
                            r_rs2   <= {w_k_next, 1'b1};
                            r_state <= S_READ;
                        end
                    end
                end

                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_rs1   <= '0;
                    r_rs2   <= '0;
                    r_k     <= '0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_rs1       = r_rs1;
    assign o_rs2       = r_rs2;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_idx   = r_out_idx;
    assign o_out_last  = r_out_last;

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Scoreboard bench for regfile_dump_ctrl. A register-file array stands in
// for the real 2R/1W file. Each dump's expected beat list is the register
// contents at start time, pushed in index order; a negedge monitor pops on
// every accepted beat and also checks hold-stability under backpressure.

module tb_regfile_dump_ctrl;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int ADDR_W = 5;

    typedef struct {
        logic [ADDR_W-1:0] idx;
        logic [XLEN-1:0]   data;
        logic              last;
    } beat_t;

    logic              clk;
    logic              rst;
    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_data;
    logic [ADDR_W-1:0] out_idx;
    logic              out_last;

    logic [XLEN-1:0]   regs [NREG];
    beat_t             sb [$];

    int checks;
    int failures;
    int cyc;
    int done_cnt;

    logic              prev_stall;
    logic [XLEN-1:0]   prev_data;
    logic [ADDR_W-1:0] prev_idx;
    logic              prev_last;

    regfile_dump_ctrl #(.XLEN(XLEN), .NREG(NREG), .ADDR_W(ADDR_W)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .o_busy      (busy),
        .o_done      (done),
        .o_rs1       (rs1),
        .o_rs2       (rs2),
        .i_rd1       (rd1),
        .i_rd2       (rd2),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_data  (out_data),
        .o_out_idx   (out_idx),
        .o_out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // x0 reads as zero regardless of array contents.
    always_comb begin
        rd1 = (rs1 == '0) ? '0 : regs[rs1];
        rd2 = (rs2 == '0) ? '0 : regs[rs2];
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!(out_valid && out_data == prev_data && out_idx == prev_idx
                      && out_last == prev_last)) begin
                    failures++;
                    $display("FAIL stall_hold: got v=%0b idx=%0d data=%h last=%0b, exp v=1 idx=%0d data=%h last=%0b",
                             out_valid, out_idx, out_data, out_last, prev_idx, prev_data, prev_last);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat: got idx=%0d data=%h, exp no beat", out_idx, out_data);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    if (out_idx != e.idx || out_data != e.data || out_last != e.last) begin
                        failures++;
                        $display("FAIL beat: got idx=%0d data=%h last=%0b, exp idx=%0d data=%h last=%0b",
                                 out_idx, out_data, out_last, e.idx, e.data, e.last);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_idx   = out_idx;
            prev_last  = out_last;
            if (done) done_cnt++;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, exp %0h", name, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  64'(busy),      64'd0);
        check({tag, "_done"},  64'(done),      64'd0);
        check({tag, "_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_data"},  64'(out_data),  64'd0);
        check({tag, "_idx"},   64'(out_idx),   64'd0);
        check({tag, "_last"},  64'(out_last),  64'd0);
        check({tag, "_rs"},    64'({rs1, rs2}), 64'd0);
    endtask

    task automatic push_expected();
        for (int i = 0; i < NREG; i++) begin
            beat_t b;
            b.idx  = ADDR_W'(i);
            b.data = (i == 0) ? '0 : regs[i];
            b.last = (i == NREG - 1);
            sb.push_back(b);
        end
    endtask

    // mode 0: ready tied high; 1: 4-cycle stall on idx 6 then random; 2: random
    task automatic run_dump(input int mode, input bit extra_starts, input bit chk_timing,
                            input bit write7, input logic [XLEN-1:0] w7_val);
        int  d0;
        int  stall_n;
        bit  first_seen;
        bit  got_done;
        bit  written;
        push_expected();
        d0         = done_cnt;
        stall_n    = 0;
        first_seen = 0;
        got_done   = 0;
        written    = 0;
        out_ready  = 1'b1;
        start      = 1'b1;
        @(posedge clk); #1;
        for (int n = 1; n < 600 && !got_done; n++) begin
            start = extra_starts && (n == 10 || n == 30);
            check("busy_during_dump", 64'(busy), 64'd1);
            case (mode)
                0: out_ready = 1'b1;
                1: begin
                    if (out_valid && out_idx == 6 && stall_n < 4) begin
                        out_ready = 1'b0;
                        stall_n++;
                    end else if (stall_n >= 4) begin
                        out_ready = 1'($urandom_range(0, 1));
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (write7 && !written && out_valid && out_idx == 6) begin
                regs[7] = w7_val;
                written = 1;
            end
            if (chk_timing && !first_seen && out_valid) begin
                first_seen = 1;
                check("first_beat_cycle", 64'(n), 64'd2);
            end
            if (done) begin
                got_done = 1;
                if (chk_timing) check("done_cycle", 64'(n), 64'd49);
            end
            @(posedge clk); #1;
        end
        start     = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (!got_done) begin
            failures++;
            $display("FAIL dump_timeout: got no done, exp done within budget");
        end
        repeat (3) @(posedge clk);
        #1;
        check("done_count", 64'(done_cnt - d0), 64'd1);
        check("sb_empty", 64'(sb.size()), 64'd0);
        check("busy_after", 64'(busy), 64'd0);
        check("valid_after", 64'(out_valid), 64'd0);
        check("rs_after", 64'({rs1, rs2}), 64'd0);
        sb.delete();
    endtask

    initial begin
        int d0;
        bit hit;
        logic [XLEN-1:0] old7;
        logic [XLEN-1:0] new7;
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        done_cnt  = 0;
        prev_stall = 1'b0;
        for (int i = 0; i < NREG; i++) regs[i] = XLEN'(i * 3);
        regs[5]  = 32'd42;
        regs[31] = 32'hDEADBEEF;

        // 1. reset with random start/ready
        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start     = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            check_reset_outputs("reset");
        end
        rst = 1'b0;
        start = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;

        // 2. directed preload, ready high, latency checks
        run_dump(0, 1'b0, 1'b1, 1'b0, '0);

        // 3. backpressure on idx 6 then random ready
        for (int i = 1; i < NREG; i++) regs[i] = $urandom;
        run_dump(1, 1'b0, 1'b0, 1'b0, '0);

        // 4. start pulses at cycles 10 and 30 are ignored
        for (int i = 1; i < NREG; i++) regs[i] = $urandom;
        run_dump(0, 1'b1, 1'b1, 1'b0, '0);

        // 5. reset mid-dump on idx 12, start held with rst, then fresh dump
        push_expected();
        out_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        hit = 0;
        for (int n = 0; n < 200 && !hit; n++) begin
            if (out_valid && out_idx == 12) hit = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL idx12_timeout: got no idx 12 beat, exp idx 12 offered");
        end
        d0 = done_cnt;
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("midreset");
        sb.delete();
        rst = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midreset_no_done", 64'(done_cnt - d0), 64'd0);
        check("midreset_idle_busy", 64'(busy), 64'd0);
        run_dump(2, 1'b0, 1'b0, 1'b0, '0);

        // 6. write x7 during SEND_A of pair (6,7)
        for (int i = 1; i < NREG; i++) regs[i] = $urandom;
        old7 = regs[7];
        new7 = ~old7;
        run_dump(0, 1'b0, 1'b0, 1'b1, new7);
        check("x7_written", 64'(regs[7]), 64'(new7));
        run_dump(2, 1'b0, 1'b0, 1'b0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
